ram_write_buffer: RTL and testbench

- Write-request queue directly upstream of the multiport RAM's write port.
- Accepts write requests with a valid/ready handshake and stores them in a small FIFO.
- Drains one entry per clock onto the RAM's address/data/enable inputs, so bursty producers never lose writes.
- Sits between producer logic and the RAM; the RAM's read ports are not touched.

---
 rtl/ram_write_buffer_pkg.sv | 24 ++
 rtl/ram_write_buffer_snoop.sv | 40 ++++
 rtl/ram_write_buffer.sv | 153 +++++++++++++++
 tb/tb_ram_write_buffer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_write_buffer_pkg.sv
// Shared constants, entry layout and sizing helper for the RAM write buffer.
// The optional snoop path is enabled by defining RAM_WRITE_BUFFER_SNOOP_EN.
package ram_write_buffer_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 4;

    // Width of the external request/RAM address buses; stored addresses are
    // the low ADDR_W bits and are zero-extended on the way out.
    localparam int BUS_ADDR_W = 32;

    // Queue entry at the default widths (used by software-side models).
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } entry_t;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ram_write_buffer_snoop.sv
// Snoop matcher for the RAM write buffer: searches the valid queue entries
// for an address and returns the data of the youngest match. Only built when
// RAM_WRITE_BUFFER_SNOOP_EN is defined.
module ram_write_buffer_snoop
    import ram_write_buffer_pkg::*;
#(
    parameter  int DEPTH  = DEPTH_DEF,
    parameter  int ADDR_W = ADDR_W_DEF,
    parameter  int DATA_W = DATA_W_DEF,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic [ADDR_W-1:0] entry_addr_i [DEPTH],
    input  logic [DATA_W-1:0] entry_data_i [DEPTH],
    input  logic [DEPTH-1:0]  valid_i,
    input  logic [PTR_W-1:0]  head_i,
    input  logic [ADDR_W-1:0] query_i,
    output logic              hit_o,
    output logic [DATA_W-1:0] data_o
);

    logic [PTR_W-1:0] idx;

    // Walk entries oldest to youngest from the head; a later match overrides
    // an earlier one, so the result is the youngest pending write.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would otherwise infer a latch.
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_i + PTR_W'(k);
            if (valid_i[idx] && (entry_addr_i[idx] == query_i)) begin
                hit_o  = 1'b1;
                data_o = entry_data_i[idx];
            end
        end
    end

endmodule

// File: rtl/ram_write_buffer.sv
// Write-request FIFO in front of the RAM write port. Accepts requests on a
// valid/ready handshake and drains one entry per clock when drain is enabled.
// Optional snoop/forward path: define RAM_WRITE_BUFFER_SNOOP_EN.
module ram_write_buffer
    import ram_write_buffer_pkg::*;
#(
    parameter  int DEPTH  = DEPTH_DEF,   // power of two, >= 2
    parameter  int ADDR_W = ADDR_W_DEF,
    parameter  int DATA_W = DATA_W_DEF,
    localparam int CNT_W  = count_width(DEPTH)
) (
    input  logic                  signal_C,   // clock
    input  logic                  signal_R,   // sync active-high reset
    input  logic                  signal_V,   // request valid
    input  logic [BUS_ADDR_W-1:0] signal_I,   // request address
    input  logic [DATA_W-1:0]     signal_W,   // request data
    output logic                  signal_K,   // request ready
    input  logic                  signal_G,   // drain enable
    output logic [BUS_ADDR_W-1:0] signal_A,   // RAM write address
    output logic [DATA_W-1:0]     signal_D,   // RAM write data
    output logic                  signal_E,   // RAM write enable
    output logic [CNT_W-1:0]      signal_N,   // occupancy
    input  logic [BUS_ADDR_W-1:0] signal_Q,   // snoop query address
    output logic                  signal_H,   // snoop hit
    output logic [DATA_W-1:0]     signal_F    // snoop forwarded data
);

    localparam int PTR_W = CNT_W - 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic      not_full;
    logic      not_empty;
    logic      enq;
    logic      deq;
    wb_entry_t head;

    // Upper request/query address bits are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{signal_I, signal_Q};

    // Handshake and drain qualifiers. Ready looks only at the registered
    // count, so a full queue refuses even in a cycle where it also drains.
    assign not_full  = (count_q != CNT_W'(DEPTH));
    assign not_empty = (count_q != '0);
    assign signal_K  = !signal_R && not_full;
    assign signal_E  = !signal_R && signal_G && not_empty;
    assign enq       = signal_V && signal_K;
    assign deq       = signal_E;

    // Head entry drives the RAM port; zero when there is nothing to write.
    assign head     = mem_q[rd_ptr_q];
    assign signal_A = not_empty ? BUS_ADDR_W'(head.addr) : '0;
    assign signal_D = not_empty ? head.data : '0;
    assign signal_N = count_q;

    // Next-state for pointers and occupancy; pointers wrap naturally because
    // DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register with synchronous reset; reset drops any queued
    // writes and blocks the drain in the same cycle via signal_E.
    always_ff @(posedge signal_C) begin
        // NOTE: registers are updated with non-blocking assignments so every
        // flop samples pre-edge values regardless of block ordering.
        if (signal_R) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage: written at the write pointer on an accepted request.
    always_ff @(posedge signal_C) begin
        // NOTE: the entry array is deliberately not reset; validity comes from
        // the pointers and count, and leaving it unreset lets it map to RAM.
        if (enq) begin
            mem_q[wr_ptr_q] <= '{addr: signal_I[ADDR_W-1:0], data: signal_W};
        end
    end

`ifdef RAM_WRITE_BUFFER_SNOOP_EN
    logic [DEPTH-1:0]  valid_mask;
    logic [PTR_W-1:0]  age;
    logic [ADDR_W-1:0] snoop_addr [DEPTH];
    logic [DATA_W-1:0] snoop_data [DEPTH];
    logic              snoop_hit;
    logic [DATA_W-1:0] snoop_fwd;

    // An entry is valid when its distance from the head is below the count.
    always_comb begin
        valid_mask = '0;
        age        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age           = PTR_W'(i) - rd_ptr_q;
            valid_mask[i] = ({1'b0, age} < count_q);
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_snoop_flat
        assign snoop_addr[i] = mem_q[i].addr;
        assign snoop_data[i] = mem_q[i].data;
    end

    ram_write_buffer_snoop #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_snoop (
        .entry_addr_i (snoop_addr),
        .entry_data_i (snoop_data),
        .valid_i      (valid_mask),
        .head_i       (rd_ptr_q),
        .query_i      (signal_Q[ADDR_W-1:0]),
        .hit_o        (snoop_hit),
        .data_o       (snoop_fwd)
    );

    assign signal_H = !signal_R && snoop_hit;
    assign signal_F = signal_R ? '0 : snoop_fwd;
`else
    assign signal_H = 1'b0;
    assign signal_F = '0;
`endif

endmodule

// File: tb/tb_ram_write_buffer.sv
// Self-checking bench for ram_write_buffer: directed phases followed by random
// traffic, checked every cycle against a queue-based reference model.
`timescale 1ns/1ps
module tb_ram_write_buffer;
    import ram_write_buffer_pkg::*;

    localparam int DEPTH  = DEPTH_DEF;
    localparam int DATA_W = DATA_W_DEF;
    localparam int CNT_W  = count_width(DEPTH);
`ifdef RAM_WRITE_BUFFER_SNOOP_EN
    localparam bit SNOOP_ON = 1'b1;
`else
    localparam bit SNOOP_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              v;
    logic              g;
    logic [31:0]       req_addr;
    logic [DATA_W-1:0] req_data;
    logic [31:0]       q_addr;
    logic              k;
    logic [31:0]       ram_a;
    logic [DATA_W-1:0] ram_d;
    logic              ram_e;
    logic [CNT_W-1:0]  n;
    logic              h;
    logic [DATA_W-1:0] f;

    int n_checks = 0;
    int n_pass   = 0;
    int n_writes = 0;

    entry_t            model_q[$];
    logic [DATA_W-1:0] ref_ram [256];
    logic [DATA_W-1:0] dut_ram [256];

    always #5 clk = ~clk;

    ram_write_buffer dut (
        .signal_C (clk),
        .signal_R (rst),
        .signal_V (v),
        .signal_I (req_addr),
        .signal_W (req_data),
        .signal_K (k),
        .signal_G (g),
        .signal_A (ram_a),
        .signal_D (ram_d),
        .signal_E (ram_e),
        .signal_N (n),
        .signal_Q (q_addr),
        .signal_H (h),
        .signal_F (f)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Monitor/scoreboard: at each falling edge compare DUT outputs with the
    // model, then advance the model to what the next rising edge will do.
    logic        exp_k, exp_e, exp_h;
    logic [31:0] exp_f;
    entry_t      hd;
    always @(negedge clk) begin
        exp_k = !rst && (model_q.size() != DEPTH);
        exp_e = !rst && g && (model_q.size() != 0);
        check("ready", k, exp_k);
        check("wr_en", ram_e, exp_e);
        check("count", n, model_q.size());
        if (model_q.size() != 0) begin
            hd = model_q[0];
            check("head_addr", ram_a, {24'h0, hd.addr});
            check("head_data", ram_d, hd.data);
        end else begin
            check("empty_addr", ram_a, 0);
            check("empty_data", ram_d, 0);
        end
        exp_h = 1'b0;
        exp_f = '0;
        if (SNOOP_ON && !rst) begin
            foreach (model_q[i]) begin
                if (model_q[i].addr == q_addr[7:0]) begin
                    exp_h = 1'b1;
                    exp_f = model_q[i].data;
                end
            end
        end
        check("snoop_hit", h, exp_h);
        if (!rst) check("snoop_data", f, exp_f);

        if (ram_e) begin
            dut_ram[ram_a[7:0]] = ram_d;
            n_writes++;
        end
        if (rst) begin
            model_q.delete();
        end else begin
            if (exp_e) begin
                hd = model_q.pop_front();
                ref_ram[hd.addr] = hd.data;
            end
            if (v && exp_k) model_q.push_back('{addr: req_addr[7:0], data: req_data});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] a, input logic [DATA_W-1:0] d);
        v        = 1'b1;
        req_addr = a;
        req_data = d;
    endtask

    // Hold the current request until the DUT takes it; returns edges waited.
    task automatic wait_accept(output int cycles);
        logic acc;
        cycles = 0;
        forever begin
            @(negedge clk);
            acc = k;
            cycles++;
            tick();
            if (acc) break;
            if (cycles > 50) begin
                check("accept_timeout", 0, 1);
                break;
            end
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [DATA_W-1:0] d);
        int c;
        offer(a, d);
        wait_accept(c);
        v = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, wc0, mism;
        int stream_addr [12] = '{7, 10, 7, 11, 12, 7, 13, 14, 7, 15, 16, 7};
        logic [31:0] r;
        for (int i = 0; i < 256; i++) begin
            ref_ram[i] = '0;
            dut_ram[i] = '0;
        end
        rst = 1'b1; v = 1'b0; g = 1'b0;
        req_addr = '0; req_data = '0; q_addr = '0;

        // Reset then idle
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        check("idle_ready", k, 1);
        check("idle_wen", ram_e, 0);
        check("idle_count", n, 0);
        check("idle_addr", ram_a, 0);
        tick();

        // Single write, upper address bits dropped
        g = 1'b1;
        wc0 = n_writes;
        send(32'h105, 32'hDEADBEEF);
        repeat (4) tick();
        check("single_write_once", n_writes - wc0, 1);
        check("single_ram5", dut_ram[5], 32'hDEADBEEF);
        check("single_count", n, 0);

        // Fill and backpressure
        g = 1'b0;
        for (int a = 1; a <= 4; a++) send(a, 32'h1000 + a);
        offer(5, 32'h1005);
        repeat (3) tick();
        @(negedge clk);
        check("full_count", n, 4);
        check("full_ready", k, 0);
        tick();
        g = 1'b1;
        wait_accept(c);
        v = 1'b0;
        // Full queue refuses on the first drain edge, accepts on the next.
        check("full_accept_edges", c, 2);
        repeat (6) tick();
        for (int a = 1; a <= 5; a++) check("fill_ram", dut_ram[a], 32'h1000 + a);

        // Steady stream with simultaneous enqueue/dequeue and wrap
        for (int i = 0; i < 12; i++) begin
            offer(stream_addr[i], 32'h4000 + i);
            wait_accept(c);
            check("stream_accept_edges", c, 1);
        end
        v = 1'b0;
        repeat (3) tick();
        check("stream_ram7_last", dut_ram[7], 32'h4000 + 11);
        check("stream_ram16", dut_ram[16], 32'h4000 + 10);

        // Reset mid-drain discards the queue
        g = 1'b0;
        for (int i = 0; i < 3; i++) send(32'h40 + i, 32'h5000 + i);
        rst = 1'b1;
        g   = 1'b1;
        @(negedge clk);
        check("rst_wen", ram_e, 0);
        check("rst_ready", k, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_count", n, 0);
        repeat (3) tick();
        for (int i = 0; i < 3; i++) check("rst_no_write", dut_ram[32'h40 + i], 0);

        // Snoop: youngest match forwarded
        g = 1'b0;
        send(9, 1);
        send(3, 2);
        send(9, 7);
        q_addr = 32'h0000_0109;
        @(negedge clk);
        check("snoop_q9_hit", h, SNOOP_ON ? 64'd1 : 64'd0);
        check("snoop_q9_data", f, SNOOP_ON ? 64'd7 : 64'd0);
        tick();
        q_addr = 4;
        @(negedge clk);
        check("snoop_q4_hit", h, 0);
        tick();
        g = 1'b1;
        repeat (4) tick();

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            r        = $urandom;
            v        = ($urandom_range(0, 3) != 0);
            g        = ($urandom_range(0, 2) != 0);
            req_addr = (r & 32'hFFFF_FF00) | $urandom_range(0, 15);
            req_data = $urandom;
            q_addr   = ($urandom & 32'hFFFF_FF00) | $urandom_range(0, 15);
            rst      = ($urandom_range(0, 63) == 0);
            tick();
        end
        rst = 1'b0; v = 1'b0; g = 1'b1;
        repeat (8) tick();
        @(negedge clk);
        check("final_count", n, 0);
        mism = 0;
        for (int i = 0; i < 256; i++) if (dut_ram[i] !== ref_ram[i]) mism++;
        check("ram_image_mismatches", mism, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
